// File: rtl/mul_issue_queue_if.sv
// Handshake bundle between mul_issue_queue and its neighbours: request port,
// MUL issue/capture pins, response port and status.
interface mul_issue_queue_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                 req_valid;
    logic                 req_ready;
    logic [WIDTH-1:0]     req_a;
    logic [WIDTH-1:0]     req_b;
    logic                 mul_in_valid;
    logic [WIDTH-1:0]     mul_a;
    logic [WIDTH-1:0]     mul_b;
    logic                 mul_out_valid;
    logic [2*WIDTH-1:0]   mul_o;
    logic                 mul_stall;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [2*WIDTH-1:0]   rsp_o;
    logic [CW-1:0]        count;
    logic                 err;

    modport slave (
        input  req_valid, req_a, req_b, mul_out_valid, mul_o, mul_stall, rsp_ready,
        output req_ready, mul_in_valid, mul_a, mul_b, rsp_valid, rsp_o, count, err
    );

    modport master (
        output req_valid, req_a, req_b, mul_out_valid, mul_o, mul_stall, rsp_ready,
        input  req_ready, mul_in_valid, mul_a, mul_b, rsp_valid, rsp_o, count, err
    );
endinterface

// File: rtl/mul_issue_queue.sv
// Operand FIFO plus issue FSM in front of a shift-and-add multiplier: one
// operation in flight, product returned on a valid/ready port, watchdog on MUL.
module mul_issue_queue #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 4,
    parameter int SETTLE = WIDTH + 3
) (
    input  logic             clk,
    input  logic             rst_n,
    mul_issue_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = $clog2(SETTLE + 1);
    localparam int WW = $clog2(WIDTH + 6);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(SETTLE - 1);
    localparam logic [WW-1:0] WD_LIMIT   = WW'(WIDTH + 4);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } opnd_t;

    typedef enum logic [2:0] {
        S_FLUSH,
        S_IDLE,
        S_ISSUE,
        S_BUSY,
        S_RESP
    } state_e;

    opnd_t              mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]      count_q, count_d;

    state_e             state_q;
    logic [FW-1:0]      flush_cnt_q;
    logic [WW-1:0]      wd_q;
    logic               in_valid_q;
    logic [WIDTH-1:0]   mul_a_q, mul_b_q;
    logic               rsp_valid_q;
    logic [2*WIDTH-1:0] rsp_q;
    logic               err_q;

    logic               push, pop, mul_quiet;
    opnd_t              head;

    assign mul_quiet     = !bus.mul_out_valid && !bus.mul_stall;
    assign bus.req_ready = (count_q < CW'(DEPTH));
    assign push          = bus.req_valid && bus.req_ready;
    assign pop           = (state_q == S_IDLE) && (count_q != '0) && mul_quiet;
    assign head          = mem_q[rd_ptr_q];

    assign bus.count        = count_q;
    assign bus.mul_in_valid = in_valid_q;
    assign bus.mul_a        = mul_a_q;
    assign bus.mul_b        = mul_b_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_o        = rsp_q;
    assign bus.err          = err_q;

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !push)
            count_d = count_q - 1'b1;
    end

    // Storage needs no reset: occupancy and pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= {bus.req_a, bus.req_b};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FLUSH;
            flush_cnt_q <= '0;
            wd_q        <= '0;
            in_valid_q  <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                // MUL may still hold an operation from before reset; wait until
                // it has been quiet long enough to have drained.
                S_FLUSH: begin
                    if (mul_quiet) begin
                        if (flush_cnt_q == FLUSH_LAST) begin
                            flush_cnt_q <= '0;
                            state_q     <= S_IDLE;
                        end else begin
                            flush_cnt_q <= flush_cnt_q + 1'b1;
                        end
                    end else begin
                        flush_cnt_q <= '0;
                    end
                end
                S_IDLE: begin
                    if (pop) begin
                        mul_a_q    <= head.a;
                        mul_b_q    <= head.b;
                        in_valid_q <= 1'b1;
                        state_q    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!bus.mul_stall) begin
                        in_valid_q <= 1'b0;
                        wd_q       <= '0;
                        state_q    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (bus.mul_out_valid) begin
                        rsp_q       <= bus.mul_o;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else if (!bus.mul_stall) begin
                        if (wd_q == WD_LIMIT) begin
                            err_q       <= 1'b1;
                            flush_cnt_q <= '0;
                            state_q     <= S_FLUSH;
                        end else begin
                            wd_q <= wd_q + 1'b1;
                        end
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_FLUSH;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_issue_queue.sv
// Bench for mul_issue_queue with a behavioural shift-and-add MUL attached and a
// response scoreboard fed on every accepted request.
module tb_mul_issue_queue;
    localparam int W = 16;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mul_issue_queue_if #(.WIDTH(W), .DEPTH(D)) ifc ();

    mul_issue_queue #(.WIDTH(W), .DEPTH(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s: bound expired", nm);
    endtask

    // Behavioural MUL: latency 2 (zero operand) or 2+bitlen(b), frozen by stall,
    // out_valid held for 2 unstalled cycles.
    logic          m_ov = 1'b0;
    logic [2*W-1:0] m_prod = '0;
    logic          m_busy = 1'b0;
    int            m_cnt = 0;
    int            m_ovc = 0;
    logic          mul_dead = 1'b0;

    function automatic int lat(input logic [W-1:0] a, input logic [W-1:0] b);
        if (a == '0 || b == '0) return 2;
        for (int i = W - 1; i >= 0; i--)
            if (b[i]) return 3 + i;
        return 2;
    endfunction

    always @(posedge clk) begin
        if (!ifc.mul_stall) begin
            if (m_ovc > 0) begin
                m_ovc <= m_ovc - 1;
                if (m_ovc == 1) m_ov <= 1'b0;
            end
            if (m_busy) begin
                if (m_cnt == 1) begin
                    m_busy <= 1'b0;
                    m_ov   <= 1'b1;
                    m_ovc  <= 2;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end else if (ifc.mul_in_valid) begin
                m_busy <= 1'b1;
                m_cnt  <= lat(ifc.mul_a, ifc.mul_b) - 1;
                m_prod <= (2*W)'(ifc.mul_a) * (2*W)'(ifc.mul_b);
            end
        end
    end

    assign ifc.mul_out_valid = m_ov && !mul_dead;
    assign ifc.mul_o         = m_prod;

    // Scoreboard and event counters, sampled on the falling edge.
    logic          sb_en = 1'b1;
    logic [2*W-1:0] exp_cur = '0;
    logic [2*W-1:0] sbq[$];
    logic          prev_iv = 1'b0;
    int            issue_cnt = 0;
    int            rsp_cnt = 0;

    always @(negedge clk) begin
        if (ifc.req_valid && ifc.req_ready && sb_en) sbq.push_back(exp_cur);
        if (ifc.mul_in_valid && !prev_iv) issue_cnt <= issue_cnt + 1;
        prev_iv <= ifc.mul_in_valid;
        if (ifc.rsp_valid) rsp_cnt <= rsp_cnt + 1;
        if (ifc.rsp_valid && ifc.rsp_ready) begin
            if (sbq.size() == 0) fail("rsp_unexpected");
            else chk("rsp_o", 64'(ifc.rsp_o), 64'(sbq.pop_front()));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] p);
        logic acc;
        acc = 1'b0;
        ifc.req_a     = a;
        ifc.req_b     = b;
        exp_cur       = p;
        ifc.req_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            acc = ifc.req_ready;
            tick(1);
            if (acc) break;
        end
        if (!acc) fail("push_timeout");
        ifc.req_valid = 1'b0;
    endtask

    task automatic wait_drain(input int n);
        for (int i = 0; i < n && sbq.size() != 0; i++) tick(1);
        if (sbq.size() != 0) fail("drain_timeout");
        tick(3);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_in_valid"},  64'(ifc.mul_in_valid), 0);
        chk({tag, "_rsp_valid"}, 64'(ifc.rsp_valid), 0);
        chk({tag, "_err"},       64'(ifc.err), 0);
        chk({tag, "_count"},     64'(ifc.count), 0);
        chk({tag, "_mul_a"},     64'(ifc.mul_a), 0);
        chk({tag, "_mul_b"},     64'(ifc.mul_b), 0);
        chk({tag, "_rsp_o"},     64'(ifc.rsp_o), 0);
        chk({tag, "_req_ready"}, 64'(ifc.req_ready), 1);
    endtask

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] p;
    } vec_t;

    vec_t tbl [9];

    initial begin : watchdog_timer
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base_iss, base_rsp;
        tbl[0] = '{16'd2,     16'd7,     32'd14};
        tbl[1] = '{16'd0,     16'd9,     32'd0};
        tbl[2] = '{16'd65535, 16'd65535, 32'd4294836225};
        tbl[3] = '{16'd1,     16'd1,     32'd1};
        tbl[4] = '{16'd7,     16'd0,     32'd0};
        tbl[5] = '{16'd0,     16'd0,     32'd0};
        tbl[6] = '{16'd255,   16'd256,   32'd65280};
        tbl[7] = '{16'd40000, 16'd3,     32'd120000};
        tbl[8] = '{16'd12345, 16'd1,     32'd12345};

        ifc.req_valid = 1'b0;
        ifc.req_a     = '0;
        ifc.req_b     = '0;
        ifc.rsp_ready = 1'b1;
        ifc.mul_stall = 1'b0;

        // Reset state, then flush length and first single operation.
        tick(2);
        chk_reset("rst");
        rst_n = 1'b1;
        push(16'd3, 16'd5, 32'd15);
        tick(18);
        chk("flush_no_issue", 64'(issue_cnt), 0);
        chk("flush_count", 64'(ifc.count), 1);
        tick(1);
        chk("issue_iv", 64'(ifc.mul_in_valid), 1);
        chk("issue_a", 64'(ifc.mul_a), 3);
        chk("issue_b", 64'(ifc.mul_b), 5);
        chk("issue_count", 64'(ifc.count), 0);
        tick(4);
        chk("mul_ov_early", 64'(ifc.mul_out_valid), 0);
        tick(1);
        chk("mul_ov_5", 64'(ifc.mul_out_valid), 1);
        tick(1);
        chk("rsp_valid_up", 64'(ifc.rsp_valid), 1);
        tick(1);
        chk("rsp_valid_1cyc", 64'(ifc.rsp_valid), 0);
        wait_drain(20);

        // Back-pressure: fill FIFO while the response is held.
        ifc.rsp_ready = 1'b0;
        base_iss = issue_cnt;
        for (int i = 0; i < 5; i++) push(tbl[i].a, tbl[i].b, tbl[i].p);
        chk("bp_count_full", 64'(ifc.count), 4);
        chk("bp_req_ready", 64'(ifc.req_ready), 0);
        for (int i = 0; i < 60 && !ifc.rsp_valid; i++) tick(1);
        if (!ifc.rsp_valid) fail("bp_rsp_wait");
        tick(5);
        chk("bp_rsp_held", 64'(ifc.rsp_valid), 1);
        chk("bp_rsp_val", 64'(ifc.rsp_o), 64'(tbl[0].p));
        chk("bp_one_issue", 64'(issue_cnt - base_iss), 1);
        ifc.req_a = tbl[5].a;
        ifc.req_b = tbl[5].b;
        exp_cur = tbl[5].p;
        ifc.req_valid = 1'b1;
        tick(3);
        chk("bp_no_accept", 64'(ifc.count), 4);
        ifc.rsp_ready = 1'b1;
        for (int i = 5; i < 9; i++) push(tbl[i].a, tbl[i].b, tbl[i].p);
        wait_drain(400);
        chk("bp_count_empty", 64'(ifc.count), 0);

        // Stall held for 3 cycles while in ISSUE.
        push(16'd6, 16'd7, 32'd42);
        tick(1);
        chk("st_iv0", 64'(ifc.mul_in_valid), 1);
        ifc.mul_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("st_iv", 64'(ifc.mul_in_valid), 1);
            chk("st_a", 64'(ifc.mul_a), 6);
            chk("st_b", 64'(ifc.mul_b), 7);
        end
        ifc.mul_stall = 1'b0;
        tick(1);
        chk("st_iv_drop", 64'(ifc.mul_in_valid), 0);
        chk("st_err", 64'(ifc.err), 0);
        wait_drain(40);

        // Watchdog: MUL never answers.
        sb_en = 1'b0;
        mul_dead = 1'b1;
        base_rsp = rsp_cnt;
        push(16'd9, 16'd9, 32'd81);
        tick(22);
        chk("wd_err_before", 64'(ifc.err), 0);
        tick(1);
        chk("wd_err_set", 64'(ifc.err), 1);
        mul_dead = 1'b0;
        sb_en = 1'b1;
        push(16'd4, 16'd5, 32'd20);
        tick(18);
        chk("wd_flush_hold", 64'(ifc.mul_in_valid), 0);
        chk("wd_no_rsp", 64'(rsp_cnt - base_rsp), 0);
        tick(1);
        chk("wd_reissue", 64'(ifc.mul_in_valid), 1);
        wait_drain(40);
        chk("wd_err_sticky", 64'(ifc.err), 1);

        // Asynchronous reset during BUSY with two entries queued.
        sb_en = 1'b0;
        base_iss = issue_cnt;
        base_rsp = rsp_cnt;
        push(16'd100, 16'd200, 32'd20000);
        push(16'd5, 16'd6, 32'd30);
        push(16'd7, 16'd8, 32'd56);
        chk("ar_count_pre", 64'(ifc.count), 2);
        tick(2);
        rst_n = 1'b0;
        #1;
        chk_reset("ar");
        tick(2);
        rst_n = 1'b1;
        tick(40);
        chk("ar_no_rsp", 64'(rsp_cnt - base_rsp), 0);
        chk("ar_no_reissue", 64'(issue_cnt - base_iss), 1);
        sb_en = 1'b1;
        push(16'd11, 16'd13, 32'd143);
        wait_drain(60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
